// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
//   spi_state_t : transfer state encoding (idle, shifting, chip-select hold)
//   SPI_MODEn   : SPI mode constants, packed as {cpol, cpha}
//   rxBitIndex  : maps the n-th received bit to its position in the received
//                 word for LSB-first or MSB-first framing
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Bit n of the serial stream is bit n of the word when LSB-first, and
    // bit width-1-n when MSB-first.
    function automatic int unsigned rxBitIndex(input int unsigned bitNum,
                                               input int unsigned width,
                                               input logic        lsbFirst);
        if (lsbFirst)
            return bitNum;
        else
            return width - 1 - bitNum;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator for the SPI master.
// Ports:
//   clk, reset  : system clock, asynchronous active-low reset
//   count       : divider runs (high while a transfer or CS hold is active)
//   toggleEn    : SCLK may toggle on divider wrap (high only while shifting)
//   idleLevel   : level SCLK is loaded with while not counting (cpol)
//   sclk        : serial clock register
//   tick        : divider wrap strobe (one clk cycle every CLK_DIV cycles)
//   lead, trail : strobes for the odd (leading) / even (trailing) SCLK edges
//   edgeCnt     : number of SCLK edges already produced in this transfer
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int EDGE_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count,
    input  logic              toggleEn,
    input  logic              idleLevel,
    output logic              sclk,
    output logic              tick,
    output logic              lead,
    output logic              trail,
    output logic [EDGE_W-1:0] edgeCnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCnt;

    // edgeCnt holds the edges already made, so an even count means the
    // edge about to happen is an odd (leading) one.
    assign tick  = count && (divCnt == DIV_LAST);
    assign lead  = tick && toggleEn && !edgeCnt[0];
    assign trail = tick && toggleEn &&  edgeCnt[0];

    // While idle the counters sit at zero and SCLK tracks the idle level, so
    // the accept edge leaves everything primed for the first half-period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt  <= '0;
            edgeCnt <= '0;
            sclk    <= 1'b0;
        end else if (!count) begin
            divCnt  <= '0;
            edgeCnt <= '0;
            sclk    <= idleLevel;
        end else if (tick) begin
            divCnt <= '0;
            if (toggleEn) begin
                sclk    <= ~sclk;
                edgeCnt <= edgeCnt + 1'b1;
            end
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with runtime-selectable mode (CPOL/CPHA) and a
// busy/done handshake.
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   start               : transfer request, taken only while idle
//   cpol, cpha          : SPI mode, latched when a request is accepted
//   slaveSelect         : target slave index, latched at accept
//   masterDataToSend    : transmit word, latched at accept
//   masterDataReceived  : last received word, updated with done
//   busy                : high from the accept edge until the done edge
//   done                : one-cycle pulse at transfer end
//   SCLK, CS, MOSI, MISO: SPI bus (CS one-hot active-low)
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 1,
    parameter int LSB_FIRST  = 1,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SEL_W-1:0]      slaveSelect,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic [NUM_SLAVES-1:0] CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam logic [EDGE_W-1:0]     LAST_EDGE   = EDGE_W'(2 * DATA_WIDTH - 1);
    localparam logic [SEL_W:0]        SLAVE_LIMIT = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] CS_ONE      = NUM_SLAVES'(1);

    spi_state_t state;
    spi_state_t stateNext;

    logic [1:0]            modeReg;
    logic                  cphaLatched;
    logic [DATA_WIDTH-1:0] txShift;
    logic [DATA_WIDTH-1:0] rxShift;
    logic                  accept;
    logic                  tick;
    logic                  lead;
    logic                  trail;
    logic                  driveEdge;
    logic                  sampleEdge;
    logic [EDGE_W-1:0]     edgeCnt;
    logic [IDX_W-1:0]      rxIdx;

    function automatic logic firstBit(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shiftOut(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    // Out-of-range selects are dropped here so they never leave idle.
    assign accept = (state == ST_IDLE) && start && ({1'b0, slaveSelect} < SLAVE_LIMIT);
    assign busy   = (state != ST_IDLE);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .EDGE_W  (EDGE_W)
    ) clkGen (
        .clk       (clk),
        .reset     (reset),
        .count     (state != ST_IDLE),
        .toggleEn  (state == ST_XFER),
        .idleLevel (cpol),
        .sclk      (SCLK),
        .tick      (tick),
        .lead      (lead),
        .trail     (trail),
        .edgeCnt   (edgeCnt)
    );

    always_comb begin
        cphaLatched = 1'b0;
        case (modeReg)
            SPI_MODE0, SPI_MODE2: cphaLatched = 1'b0;
            SPI_MODE1, SPI_MODE3: cphaLatched = 1'b1;
            default:              cphaLatched = 1'b0;
        endcase
    end

    // With cpha=0 the first bit went out at accept, so later bits follow the
    // trailing edges, except the final one where nothing is left to send.
    // Edge k sees edgeCnt=k-1, so (edgeCnt>>1) is the received bit number in
    // both phases.
    assign driveEdge  = cphaLatched ? lead : (trail && (edgeCnt != LAST_EDGE));
    assign sampleEdge = cphaLatched ? trail : lead;
    assign rxIdx      = IDX_W'(rxBitIndex(32'(edgeCnt >> 1), DATA_WIDTH, LSB_FIRST != 0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (accept)                          stateNext = ST_XFER;
            ST_XFER: if (trail && (edgeCnt == LAST_EDGE)) stateNext = ST_HOLD;
            ST_HOLD: if (tick)                            stateNext = ST_IDLE;
            default:                                      stateNext = ST_IDLE;
        endcase
    end

    // Bus outputs, shift registers and the done/received-word handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CS                 <= '1;
            MOSI               <= 1'b0;
            done               <= 1'b0;
            masterDataReceived <= '0;
            txShift            <= '0;
            rxShift            <= '0;
            modeReg            <= SPI_MODE0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    CS   <= '1;
                    MOSI <= 1'b0;
                    if (accept) begin
                        modeReg <= {cpol, cpha};
                        CS      <= ~(CS_ONE << slaveSelect);
                        rxShift <= '0;
                        if (!cpha) begin
                            MOSI    <= firstBit(masterDataToSend);
                            txShift <= shiftOut(masterDataToSend);
                        end else begin
                            txShift <= masterDataToSend;
                        end
                    end
                end
                ST_XFER: begin
                    if (driveEdge) begin
                        MOSI    <= firstBit(txShift);
                        txShift <= shiftOut(txShift);
                    end
                    if (sampleEdge)
                        rxShift[rxIdx] <= MISO;
                end
                ST_HOLD: begin
                    if (tick) begin
                        CS                 <= '1;
                        MOSI               <= 1'b0;
                        done               <= 1'b1;
                        masterDataReceived <= rxShift;
                    end
                end
                default: begin
                    CS   <= '1;
                    MOSI <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed testbench for spi_master_param. Three instances cover the default
// configuration, a slow SCLK divider and a 16-bit MSB-first variant. Each has
// a small SPI slave model that drives MISO from a reference word and captures
// MOSI on the slave's sampling edges.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // dut0: defaults (8 bit, 3 slaves, CLK_DIV=1, LSB first)
    logic       start0, cpol0, cpha0, busy0, done0, sclk0, mosi0, miso0;
    logic [1:0] sel0;
    logic [7:0] tx0, rxd0;
    logic [2:0] cs0;
    // dut1: CLK_DIV=4
    logic       start1, cpol1, cpha1, busy1, done1, sclk1, mosi1, miso1;
    logic [1:0] sel1;
    logic [7:0] tx1, rxd1;
    logic [2:0] cs1;
    // dut2: 16 bit, MSB first
    logic        start2, cpol2, cpha2, busy2, done2, sclk2, mosi2, miso2;
    logic [1:0]  sel2;
    logic [15:0] tx2, rxd2;
    logic [2:0]  cs2;

    spi_master_param dut0 (
        .clk(clk), .reset(reset), .start(start0), .cpol(cpol0), .cpha(cpha0),
        .slaveSelect(sel0), .masterDataToSend(tx0), .masterDataReceived(rxd0),
        .busy(busy0), .done(done0), .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0));

    spi_master_param #(.CLK_DIV(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .cpol(cpol1), .cpha(cpha1),
        .slaveSelect(sel1), .masterDataToSend(tx1), .masterDataReceived(rxd1),
        .busy(busy1), .done(done1), .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1));

    spi_master_param #(.DATA_WIDTH(16), .LSB_FIRST(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cpol(cpol2), .cpha(cpha2),
        .slaveSelect(sel2), .masterDataToSend(tx2), .masterDataReceived(rxd2),
        .busy(busy2), .done(done2), .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .MISO(miso2));

    // Slave-side view: the bit the slave presents after `edges` SCLK edges.
    function automatic logic slaveBit(input logic [15:0] w, input int edges,
                                      input logic cph, input logic lsb, input int width);
        int n;
        n = cph ? (edges - 1) / 2 : edges / 2;
        if (n < 0 || n >= width)
            return 1'b0;
        return lsb ? w[n] : w[width-1-n];
    endfunction

    function automatic int capIdx(input int edges, input logic lsb, input int width);
        int n;
        n = (edges - 1) / 2;
        return lsb ? n : width - 1 - n;
    endfunction

    logic [15:0] sTx0, sTx1, sTx2;
    logic [15:0] cap0, cap1, cap2;
    logic        m0Cpha, m1Cpha, m2Cpha;
    logic        first0, first1, first2;
    logic        sPrev0 = 1'b0, sPrev1 = 1'b0, sPrev2 = 1'b0;
    int          sEdge0 = 0, sEdge1 = 0, sEdge2 = 0;

    // Slave model for dut0
    always @(sclk0 or cs0) begin
        if (&cs0)
            sEdge0 = 0;
        else if (sclk0 !== sPrev0) begin
            sEdge0++;
            if (sEdge0 == 1) cap0 = '0;
            if ((sEdge0 % 2) == (m0Cpha ? 0 : 1)) begin
                cap0[capIdx(sEdge0, 1'b1, 8)] = mosi0;
                if ((sEdge0 - 1) / 2 == 0) first0 = mosi0;
            end
        end
        sPrev0 = sclk0;
    end
    assign miso0 = slaveBit(sTx0, sEdge0, m0Cpha, 1'b1, 8);

    // Slave model for dut1
    always @(sclk1 or cs1) begin
        if (&cs1)
            sEdge1 = 0;
        else if (sclk1 !== sPrev1) begin
            sEdge1++;
            if (sEdge1 == 1) cap1 = '0;
            if ((sEdge1 % 2) == (m1Cpha ? 0 : 1)) begin
                cap1[capIdx(sEdge1, 1'b1, 8)] = mosi1;
                if ((sEdge1 - 1) / 2 == 0) first1 = mosi1;
            end
        end
        sPrev1 = sclk1;
    end
    assign miso1 = slaveBit(sTx1, sEdge1, m1Cpha, 1'b1, 8);

    // Slave model for dut2 (MSB first, 16 bit)
    always @(sclk2 or cs2) begin
        if (&cs2)
            sEdge2 = 0;
        else if (sclk2 !== sPrev2) begin
            sEdge2++;
            if (sEdge2 == 1) cap2 = '0;
            if ((sEdge2 % 2) == (m2Cpha ? 0 : 1)) begin
                cap2[capIdx(sEdge2, 1'b0, 16)] = mosi2;
                if ((sEdge2 - 1) / 2 == 0) first2 = mosi2;
            end
        end
        sPrev2 = sclk2;
    end
    assign miso2 = slaveBit(sTx2, sEdge2, m2Cpha, 1'b0, 16);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        start0 = 0; cpol0 = 0; cpha0 = 0; sel0 = 0; tx0 = 0;
        start1 = 0; cpol1 = 0; cpha1 = 0; sel1 = 0; tx1 = 0;
        start2 = 0; cpol2 = 0; cpha2 = 0; sel2 = 0; tx2 = 0;
        sTx0 = 0; sTx1 = 0; sTx2 = 0;
        m0Cpha = 0; m1Cpha = 0; m2Cpha = 0;
    endtask

    int   n;
    logic bad;

    initial begin
        applyStimulus();
        reset = 1'b1;
        #2 reset = 1'b0;
        #10;
        checkOutput("rst_cs", cs0, 3'b111);
        checkOutput("rst_sclk", sclk0, 1'b0);
        checkOutput("rst_mosi", mosi0, 1'b0);
        checkOutput("rst_busy", busy0, 1'b0);
        checkOutput("rst_done", done0, 1'b0);
        checkOutput("rst_rx", rxd0, 8'h00);
        @(negedge clk) reset = 1'b1;

        // Out-of-range slave select is ignored
        @(negedge clk);
        sel0 = 2'd3; start0 = 1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || done0 !== 1'b0 || cs0 !== 3'b111 || sclk0 !== 1'b0) bad = 1;
        end
        start0 = 0;
        checkOutput("oor_ignored", bad, 1'b0);

        // Mode 0, slave 0, tx 0x2B, rx 0x09
        @(negedge clk);
        sel0 = 0; tx0 = 8'h2B; sTx0 = 16'h0009; m0Cpha = 0; start0 = 1;
        @(negedge clk) start0 = 0;
        checkOutput("m0_busy", busy0, 1'b1);
        n = 0; bad = 0;
        while (!done0 && n < 200) begin
            if (cs0 !== 3'b110) bad = 1;
            @(negedge clk); n++;
        end
        checkOutput("m0_done_cycle", n, 17);
        checkOutput("m0_rx", rxd0, 8'h09);
        checkOutput("m0_mosi", cap0[7:0], 8'h2B);
        checkOutput("m0_cs", bad, 1'b0);
        checkOutput("m0_busy_at_done", busy0, 1'b0);
        checkOutput("m0_cs_release", cs0, 3'b111);
        @(negedge clk);
        checkOutput("m0_done_pulse", done0, 1'b0);

        // Mode 3 on CLK_DIV=4 instance, slave 1
        cpol1 = 1; cpha1 = 1; m1Cpha = 1;
        repeat (2) @(negedge clk);
        checkOutput("m3_sclk_idle", sclk1, 1'b1);
        sel1 = 2'd1; tx1 = 8'hA5; sTx1 = 16'h0025; start1 = 1;
        @(negedge clk) start1 = 0;
        n = 0; bad = 0;
        while (!done1 && n < 400) begin
            if (cs1 !== 3'b101) bad = 1;
            @(negedge clk); n++;
        end
        checkOutput("m3_done_cycle", n, 68);
        checkOutput("m3_rx", rxd1, 8'h25);
        checkOutput("m3_mosi", cap1[7:0], 8'hA5);
        checkOutput("m3_cs", bad, 1'b0);
        checkOutput("m3_sclk_end", sclk1, 1'b1);

        // Mode 1, 16-bit MSB first
        cpol2 = 0; cpha2 = 1; m2Cpha = 1;
        @(negedge clk);
        sel2 = 0; tx2 = 16'h8001; sTx2 = 16'hBEEF; start2 = 1;
        @(negedge clk) start2 = 0;
        n = 0;
        while (!done2 && n < 400) begin
            @(negedge clk); n++;
        end
        checkOutput("msb_done_cycle", n, 33);
        checkOutput("msb_rx", rxd2, 16'hBEEF);
        checkOutput("msb_mosi", cap2, 16'h8001);
        checkOutput("msb_first_bit", first2, 1'b1);

        // Start during busy ignored, then back-to-back via held start
        @(negedge clk);
        cpol0 = 0; cpha0 = 0; m0Cpha = 0;
        sel0 = 0; tx0 = 8'h5A; sTx0 = 16'h00C3; start0 = 1;
        @(negedge clk) start0 = 0;
        n = 0; bad = 0;
        while (!done0 && n < 200) begin
            if (cs0 !== 3'b110) bad = 1;
            if (n == 5) begin start0 = 1; tx0 = 8'hFF; sel0 = 2'd2; cpha0 = 1; end
            if (n == 6) start0 = 0;
            if (n == 16) begin start0 = 1; tx0 = 8'h3C; sel0 = 2'd2; cpha0 = 0; end
            @(negedge clk); n++;
        end
        checkOutput("b2b_first_cycle", n, 17);
        checkOutput("b2b_first_rx", rxd0, 8'hC3);
        checkOutput("b2b_first_mosi", cap0[7:0], 8'h5A);
        checkOutput("b2b_first_cs", bad, 1'b0);
        checkOutput("b2b_idle_gap", busy0, 1'b0);
        sTx0 = 16'h0096;
        @(negedge clk) start0 = 0;
        checkOutput("b2b_rearm_busy", busy0, 1'b1);
        checkOutput("b2b_rearm_cs", cs0, 3'b011);
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk); n++;
        end
        checkOutput("b2b_second_cycle", n, 17);
        checkOutput("b2b_second_rx", rxd0, 8'h96);
        checkOutput("b2b_second_mosi", cap0[7:0], 8'h3C);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || done0 !== 1'b0 || mosi0 !== 1'b0) bad = 1;
        end
        checkOutput("b2b_quiet", bad, 1'b0);

        // Async reset after SCLK edge 5
        sel0 = 0; tx0 = 8'hF0; sTx0 = 16'h0055; start0 = 1;
        @(negedge clk) start0 = 0;
        n = 0;
        while (sEdge0 < 5 && n < 50) begin
            @(negedge clk); n++;
        end
        checkOutput("rstmid_edge5", sEdge0, 5);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstmid_cs", cs0, 3'b111);
        checkOutput("rstmid_sclk", sclk0, 1'b0);
        checkOutput("rstmid_busy", busy0, 1'b0);
        checkOutput("rstmid_mosi", mosi0, 1'b0);
        checkOutput("rstmid_rx", rxd0, 8'h00);
        @(negedge clk) reset = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) bad = 1;
        end
        checkOutput("rstmid_no_done", bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised next-generation SPI master: configurable word width, slave count, SCLK divider, bit order, and runtime-selectable CPOL/CPHA (modes 0-3).
- Adds a busy/done handshake for the host-side controller.
- Sits between the system controller and up to NUM_SLAVES SPI slaves.
- Drives SCLK, one-hot active-low chip selects and MOSI; samples MISO.

Parameters:
- DATA_WIDTH, 8: bits per transfer (>=2).
- NUM_SLAVES, 3: number of chip-select lines (>=1).
- CLK_DIV, 1: clk cycles per SCLK half-period (>=1).
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = MSB shifted first.
- SEL_W, $clog2(NUM_SLAVES) (min 1): slaveSelect width.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  transfer request; sampled only when busy=0.
- cpol  in  1  SCLK idle level; latched at accept.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
- slaveSelect  in  SEL_W  target slave index; latched at accept.
- masterDataToSend  in  DATA_WIDTH  transmit word; latched at accept.
- masterDataReceived  out  DATA_WIDTH  last received word; updates only when done rises.
- busy  out  1  high from accept edge until done edge.
- done  out  1  one-cycle pulse at transfer end.
- SCLK  out  1  serial clock.
- CS  out  NUM_SLAVES  active-low chip selects; at most one low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

Behaviour:
- Reset (async, reset=0):
  - state IDLE; CS all 1; SCLK=0; MOSI=0; busy=0; done=0.
  - masterDataReceived=0; shift registers and counters 0.
  - Reset mid-transfer aborts with no done pulse.
- States IDLE -> XFER -> HOLD -> IDLE. E0 is the accept edge.
- IDLE:
  - SCLK follows registered cpol; CS all 1; MOSI=0.
  - Accept when start=1, busy=0 and slaveSelect<NUM_SLAVES.
  - Out-of-range slaveSelect: request ignored; no busy, no done.
- On accept (E0):
  - Latch cpol, cpha, slaveSelect and data.
  - CS[slaveSelect]<=0; busy<=1; divCnt<=0; edgeCnt<=0.
  - cpha=0: MOSI<=first bit now.
- XFER:
  - divCnt counts 0..CLK_DIV-1. On wrap, SCLK toggles and edgeCnt increments.
  - SCLK edge k (1..2*DATA_WIDTH) therefore occurs at E(k*CLK_DIV).
  - cpha=0: sample MISO on odd edges; shift next bit to MOSI on even edges 2..2W-2.
  - cpha=1: drive next bit on odd edges (first bit at edge 1); sample on even edges.
  - Received bit n lands at index n (LSB_FIRST=1) or index W-1-n (LSB_FIRST=0).
  - After edge 2W, SCLK is at cpol and state -> HOLD.
- HOLD:
  - CLK_DIV cycles of CS hold.
  - At E((2W+1)*CLK_DIV): CS all 1; MOSI<=0; busy<=0; done<=1; masterDataReceived<=rx shift register; state IDLE.
- done is cleared on the next edge.
- start during busy is ignored (no queueing).
- start sampled in the done cycle is accepted: back-to-back, one idle cycle.
- cpol/cpha/data/slaveSelect changes during busy have no effect.

Decomposition:
- Shared package spi_pkg:
  - state encodings (ST_IDLE, ST_XFER, ST_HOLD);
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - helper function for received bit index.
- One sub-module spi_clk_gen (parameter CLK_DIV):
  - divCnt plus edge strobe, SCLK register with idle load, edge counter.
  - Outputs lead/trail strobes.
- Shift/control FSM stays in spi_master_param.

Test Plan:
- Mode 0, defaults:
  - Stimulus: slave 0, tx 0x2B; MISO driven with bits of 0x09, LSB first.
  - Response: MOSI on leading edges = 1,1,0,1,0,1,0,0; done at E17; masterDataReceived=0x09; CS=3'b110 during busy.
- Mode 3, CLK_DIV=4:
  - Stimulus: slave 1, tx 0xA5, rx 0x25.
  - Response: SCLK idle 1; CS=3'b101 only; done at E68; received 0x25; MOSI LSB-first of 0xA5.
- Start during busy, then back-to-back:
  - Stimulus: start pulse during busy; then start held through the done cycle.
  - Response: mid-busy start ignored, no extra done; held start accepted at done+1, busy=1 again; second transfer completes correctly.
- Async reset mid-transfer:
  - Stimulus: reset=0 after SCLK edge 5.
  - Response: immediately CS=3'b111, SCLK=0, busy=0, MOSI=0, masterDataReceived=0; no done.
- MSB-first, wide word:
  - Stimulus: LSB_FIRST=0, DATA_WIDTH=16, mode 1, tx 0x8001, rx 0xBEEF.
  - Response: first MOSI bit 1; received 0xBEEF; done at E33.
- Out-of-range select:
  - Stimulus: NUM_SLAVES=3, slaveSelect=3, start=1.
  - Response: busy stays 0; CS stays 3'b111; no done; SCLK idle.
